// File: rtl/dp_fp_pkg.sv
// IEEE-754 double-precision field constants, flag indices and a value classifier
// shared by the DP multiplier shell.
package dp_fp_pkg;

  localparam int unsigned DP_W     = 64;
  localparam int unsigned EXP_W    = 11;
  localparam int unsigned MAN_W    = 52;
  localparam int unsigned EXP_BIAS = 1023;

  localparam logic [DP_W-1:0]  DP_POS_INF = 64'h7FF0000000000000;
  localparam logic [EXP_W-1:0] EXP_MAX    = 11'h7FF;

  // Flag vector layout is {nan, inf, zero, subnormal}
  localparam int unsigned FLG_W    = 4;
  localparam int unsigned FLG_NAN  = 3;
  localparam int unsigned FLG_INF  = 2;
  localparam int unsigned FLG_ZERO = 1;
  localparam int unsigned FLG_SUB  = 0;

  function automatic logic [FLG_W-1:0] dp_classify(input logic [DP_W-1:0] v);
    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic [FLG_W-1:0] flg;
    exp_f = v[DP_W-2 -: EXP_W];
    man_f = v[MAN_W-1:0];
    flg   = '0;
    if (exp_f == EXP_MAX) begin
      flg[FLG_NAN] = (man_f != '0);
      flg[FLG_INF] = (man_f == '0);
    end else if (exp_f == '0) begin
      flg[FLG_ZERO] = (man_f == '0);
      flg[FLG_SUB]  = (man_f != '0);
    end
    return flg;
  endfunction

endpackage

// File: rtl/dp_mul_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide at any occupancy.
// Storage is cleared on reset so the head reads zero while empty after reset.
module dp_mul_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/dp_mul_issue_buffer.sv
// Valid/ready shell around a free-running fixed-latency DP multiplier.
// Optional result classification is enabled with the DP_MUL_FLAGS_EN macro.
module dp_mul_issue_buffer
  import dp_fp_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AW       = 2
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DP_W-1:0] in_a,
  input  logic [DP_W-1:0] in_b,
  output logic [DP_W-1:0] mul_a,
  output logic [DP_W-1:0] mul_b,
  input  logic [DP_W-1:0] mul_pro,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DP_W-1:0] out_data,
  output logic [3:0]      out_flags
);

`ifdef DP_MUL_FLAGS_EN
  localparam int unsigned FIFO_W = DP_W + FLG_W;
`else
  localparam int unsigned FIFO_W = DP_W;
`endif

  logic                accept;
  logic                push;
  logic                pop;
  logic [PIPE_LAT-1:0] issue_sr_q, issue_sr_d;
  logic [AW:0]         credit_q, credit_d;
  logic [AW:0]         fifo_count;
  logic [DP_W-1:0]     mul_a_q, mul_a_d;
  logic [DP_W-1:0]     mul_b_q, mul_b_d;
  logic [FIFO_W-1:0]   push_data;
  logic [FIFO_W-1:0]   head;

  // Credits cover every op from accept until its result is popped, so a
  // product arriving from the multiplier always finds a free FIFO slot.
  assign in_ready  = (credit_q < (AW + 1)'(DEPTH));
  assign accept    = in_valid & in_ready;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = issue_sr_q[PIPE_LAT-1];

  always_comb begin
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    issue_sr_d = {issue_sr_q[PIPE_LAT-2:0], accept};
    credit_d   = credit_q;
    if (accept) begin
      mul_a_d = in_a;
      mul_b_d = in_b;
    end
    case ({accept, pop})
      2'b10:   credit_d = credit_q + 1'b1;
      2'b01:   credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      issue_sr_q <= '0;
      credit_q   <= '0;
    end else begin
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      issue_sr_q <= issue_sr_d;
      credit_q   <= credit_d;
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;

`ifdef DP_MUL_FLAGS_EN
  assign push_data = {dp_classify(mul_pro), mul_pro};
  assign out_flags = head[FIFO_W-1 -: FLG_W];
`else
  assign push_data = mul_pro;
  assign out_flags = 4'b0;
`endif

  assign out_data = head[DP_W-1:0];

  dp_mul_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk         (clk),
    .nrst        (nrst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_dp_mul_issue_buffer.sv
// Scoreboard bench for dp_mul_issue_buffer with a behavioural 3-stage multiplier
// in the environment; build with DP_MUL_FLAGS_EN to also check out_flags.
module tb_dp_mul_issue_buffer;

  localparam int PIPE_LAT = 4;
  localparam int DEPTH    = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        in_ready, out_valid;
  logic [63:0] mul_a, mul_b, mul_pro, out_data;
  logic [3:0]  out_flags;

  int     tests = 0;
  int     fails = 0;
  longint edge_cnt = 0;
  longint acc_cyc = 0;
  int     acc_cnt = 0;
  logic   exp_v;
  bit     rand_run = 1'b0;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  flags;
    longint      avail;
  } exp_t;
  exp_t sb_q[$];

  dp_mul_issue_buffer #(
    .PIPE_LAT (PIPE_LAT),
    .DEPTH    (DEPTH),
    .AW       (2)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_pro   (mul_pro),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  function automatic logic [3:0] ref_flags(input logic [63:0] d);
`ifdef DP_MUL_FLAGS_EN
    if (d[62:52] == 11'h7FF) return (d[51:0] != 0) ? 4'b1000 : 4'b0100;
    if (d[62:52] == 11'h000) return (d[51:0] == 0) ? 4'b0010 : 4'b0001;
    return 4'b0000;
`else
    return 4'b0000 & d[3:0];
`endif
  endfunction

  // Free-running multiplier: three register stages, shares nrst with the DUT.
  logic [63:0] m1, m2, m3;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m1 <= '0;
      m2 <= '0;
      m3 <= '0;
    end else begin
      m1 <= fmul(mul_a, mul_b);
      m2 <= m1;
      m3 <= m2;
    end
  end
  assign mul_pro = m3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: in_ready follows outstanding count; head becomes visible PIPE_LAT
  // edges after the accept edge; results leave in issue order.
  always @(negedge clk) begin
    if (!nrst) begin
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_out_flags", {60'd0, out_flags}, 64'd0);
    end else begin
      check("in_ready", {63'd0, in_ready}, {63'd0, sb_q.size() < DEPTH});
      check("outstanding_le_depth", {63'd0, sb_q.size() <= DEPTH}, 64'd1);
      exp_v = (sb_q.size() > 0) && (edge_cnt >= sb_q[0].avail);
      check("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
      if (out_valid && exp_v) begin
        check("out_data", out_data, sb_q[0].data);
        check("out_flags", {60'd0, out_flags}, {60'd0, sb_q[0].flags});
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    int   waited = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    forever begin
      @(negedge clk);
      #1;
      if (in_ready) begin
        e.data  = fmul(a, b);
        e.flags = ref_flags(e.data);
        e.avail = edge_cnt + 1 + PIPE_LAT;
        sb_q.push_back(e);
        acc_cnt++;
        acc_cyc = edge_cnt;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("mul_a_reg", mul_a, a);
        check("mul_b_reg", mul_b, b);
        return;
      end
      waited++;
      if (waited > 200) begin
        check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_done", {63'd0, sb_q.size() == 0}, 64'd1);
  endtask

  function automatic logic [63:0] rand_op();
    logic [63:0] specials [6];
    specials[0] = 64'h0000000000000000;
    specials[1] = 64'h7FF0000000000000;
    specials[2] = 64'h000FFFFFFFFFFFFF;
    specials[3] = 64'h3FF0000000000000;
    specials[4] = 64'h7FE0000000000000;
    specials[5] = 64'h0010000000000000;
    if ($urandom_range(0, 4) == 0) return specials[$urandom_range(0, 5)];
    // Keep most exponents near the bias so products stay finite and normal.
    return {1'($urandom), 11'(1023 - 40 + $urandom_range(0, 80)), $urandom, 20'($urandom)};
  endfunction

  initial begin
    int k;
    longint base;
    int base_acc;

    // Reset values
    idle(3);
    check("rst_mul_a", mul_a, 64'd0);
    check("rst_mul_b", mul_b, 64'd0);
    nrst = 1'b1;
    idle(1);
    check("ready_after_rst", {63'd0, in_ready}, 64'd1);

    // 1: 2.0 * 3.0, latency from accept cycle to first out_valid cycle
    out_ready = 1'b1;
    issue(64'h4000000000000000, 64'h4008000000000000);
    base = acc_cyc;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("lat_cycles", 64'(edge_cnt - base), 64'(PIPE_LAT + 1));
    check("prod_2x3", out_data, 64'h4018000000000000);
    @(posedge clk);
    #1;
    drain();

    // 2: back-to-back accepts with out_ready high
    for (int i = 0; i < 8; i++) issue(64'(64'h3FF0000000000000 + i * 64'h0001000000000000),
                                      64'h4000000000000000);
    drain();

    // 3: backpressure fills credits, then release
    out_ready = 1'b0;
    base_acc  = acc_cnt;
    fork
      for (int i = 0; i < 6; i++) issue(rand_op(), rand_op());
      begin
        idle(20);
        check("bp_accepts", 64'(acc_cnt - base_acc), 64'(DEPTH));
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
      end
    join
    drain();

    // 4: zero result, 5: overflow to +inf
    issue(64'h0000000000000000, 64'h4014000000000000);
    issue(64'h7FE0000000000000, 64'h7FE0000000000000);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("prod_zero", out_data, 64'h0);
    check("flags_zero", {60'd0, out_flags}, 64'(ref_flags(64'h0)));
    @(negedge clk);
    check("prod_inf", out_data, 64'h7FF0000000000000);
    check("flags_inf", {60'd0, out_flags}, 64'(ref_flags(64'h7FF0000000000000)));
    @(posedge clk);
    #1;
    drain();

    // 6: reset with two results buffered and two in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(rand_op(), rand_op());
    idle(2);
    nrst = 1'b0;
    sb_q.delete();
    idle(3);
    nrst = 1'b1;
    idle(1);
    check("rst_mid_ready", {63'd0, in_ready}, 64'd1);
    check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    idle(12);

    // Randomized traffic with random downstream stalls
    rand_run = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          issue(rand_op(), rand_op());
        end
        rand_run = 1'b0;
      end
      while (rand_run) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    drain();
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
